mul4_fitness_sched: RTL and testbench
=====================================

# mul4_fitness_sched

Evaluation scheduler for the bit-sliced 2x2-bit multiplier candidates (16-bit lane vectors a1/a0/b1/b0 → y3..y0). The block time-shares one candidate-evaluation port among NUM_CAND candidates. It selects each candidate in turn and drives the exhaustive 16-lane stimulus. It then scores the returned product bits against the golden product and runs a tournament that reports the best candidate. It sits between the candidate mux (driven by cand_sel) and the evolutionary controller (start/done).

## Interface
- NUM_CAND, 4: number of candidates scheduled per tournament (≥2).
- SETTLE, 1: cycles held after cand_sel/stimulus change before sampling outputs (≥1).
- IDX_W, $clog2(NUM_CAND): index width.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin tournament; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse, tournament complete.
- cand_sel  out  IDX_W  candidate currently connected to the evaluation port.
- a1, a0, b1, b0  out  16 each  lane stimulus.
- y3, y2, y1, y0  in  16 each  candidate outputs (combinational, from the selected candidate).
- score_valid  out  1  one-cycle pulse per candidate score.
- score_idx  out  IDX_W  candidate that score_out belongs to.
- score_out  out  7  correct output bits, 0..64.
- best_idx  out  IDX_W  tournament winner; valid from the done pulse and held until the next start.
- best_score  out  7  winner's score.

## Operation
- Lane i encodes a = i[3:2], b = i[1:0]. Stimulus constants: a1=16'hFF00, a0=16'hF0F0, b1=16'hCCCC, b0=16'hAAAA.
- Golden product: e0=16'hA0A0, e1=16'h6AC0, e2=16'h4C00, e3=16'h8000.
- Stimulus is driven only in SETTLE/SCORE/UPDATE; it is 0 otherwise.
- FSM states:
  - IDLE: start=1 → SETTLE; clears acc, best_*, cand_sel=0.
  - SETTLE: hold for SETTLE cycles → SCORE with k=0.
  - SCORE: 4 cycles, k=0..3. Each cycle acc += popcount(~(y_k ^ e_k)).
  - UPDATE: 1 cycle. Pulse score_valid with score_out=acc and score_idx=cand_sel. The winner register loads if this is candidate 0, or if acc > best_score (strict). Ties keep the lower index. Then, if cand_sel==NUM_CAND-1 → DONE; else cand_sel++, acc=0 → SETTLE.
  - DONE: 1 cycle, done=1, busy=0 → IDLE.
- Score width: 7 bits, no saturation needed (max 64).
- start while not in IDLE is ignored; no queuing.
- rst in any state → IDLE the next cycle, aborting the tournament. No done or score_valid pulse is emitted.

## Timing
- Reset values: busy=0, done=0, score_valid=0, cand_sel=0, a*/b*=0, score_idx=0, score_out=0, best_idx=0, best_score=0.
- Start sampled at edge 0 → busy=1 and stimulus valid from cycle 1.
- Per-candidate period: SETTLE+5 cycles.
- done asserts at cycle 1+NUM_CAND·(SETTLE+5). Defaults give cycle 25.
- y_k are sampled at the SCORE edges only; input changes during SETTLE are don't-care.
- score_valid for candidate n asserts in cycle 1+n·(SETTLE+5)+SETTLE+4.
- A back-to-back start in the cycle after done is accepted (IDLE is reached).

## Structure
- Package mul4_eval_pkg holds:
  - the stimulus and golden constants (A1_VEC, A0_VEC, B1_VEC, B0_VEC, EXP_VEC[4]);
  - the state enum (IDLE, SETTLE, SCORE, UPDATE, DONE);
  - SCORE_W=7.
- One sub-module, mul4_popcount16: combinational 16-bit population count (5-bit result), instantiated once on ~(y_k ^ e_k) via a 4:1 word mux indexed by k.
- Counters: settle counter, k (2 bits), cand_sel.

## Test plan
- All candidates model an ideal multiplier (y = golden) → four score_valid pulses with score 64; best_idx=0, best_score=64; done at cycle 25.
- Candidate 2 ideal, others drive all-zero → scores 50,50,64,50; best_idx=2, best_score=64.
- Candidate 0 drives all-ones, candidate 1 all-zero, 2–3 all-ones → scores 14,50,14,14; best_idx=1, best_score=50.
- rst asserted at cycle 10 mid-tournament → next cycle busy=0, all outputs at reset values, no done. A fresh start then completes normally.
- start pulsed at cycles 0 and 5 → only one tournament runs; done at cycle 25 only.
- SETTLE=3: a candidate whose outputs are wrong until 2 cycles after cand_sel changes, then ideal → every score is 64; done at cycle 1+4·8=33.

Source files
------------

// File: rtl/mul4_eval_pkg.sv
// mul4_eval_pkg: stimulus/golden lane constants, scheduler states and score width for the 2x2 multiplier evaluator.
package mul4_eval_pkg;
  localparam int SCORE_W = 7;
  localparam logic [15:0] A1_VEC = 16'hFF00;
  localparam logic [15:0] A0_VEC = 16'hF0F0;
  localparam logic [15:0] B1_VEC = 16'hCCCC;
  localparam logic [15:0] B0_VEC = 16'hAAAA;
  localparam logic [15:0] EXP_VEC [4] = '{16'hA0A0, 16'h6AC0, 16'h4C00, 16'h8000};
  typedef enum logic [2:0] {IDLE, SETTLE, SCORE, UPDATE, DONE} state_e;
endpackage

// File: rtl/mul4_popcount16.sv
// mul4_popcount16: combinational population count of a 16-bit word.
module mul4_popcount16 (
  input  logic [15:0] v_i,
  output logic [4:0]  cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 16; i++) cnt_o = cnt_o + 5'(v_i[i]);
  end
endmodule

// File: rtl/mul4_fitness_sched.sv
// mul4_fitness_sched: time-shares one evaluation port across candidates, scores each against the golden product and tracks the best.
module mul4_fitness_sched
  import mul4_eval_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int SETTLE   = 1,
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   cand_sel,
  output logic [15:0]        a1,
  output logic [15:0]        a0,
  output logic [15:0]        b1,
  output logic [15:0]        b0,
  input  logic [15:0]        y3,
  input  logic [15:0]        y2,
  input  logic [15:0]        y1,
  input  logic [15:0]        y0,
  output logic               score_valid,
  output logic [IDX_W-1:0]   score_idx,
  output logic [SCORE_W-1:0] score_out,
  output logic [IDX_W-1:0]   best_idx,
  output logic [SCORE_W-1:0] best_score
);
  localparam int CNT_W = SETTLE > 1 ? $clog2(SETTLE) : 1;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] k_q, k_d;
  logic [IDX_W-1:0] sel_q, sel_d, best_idx_q, best_idx_d;
  logic [SCORE_W-1:0] acc_q, acc_d, best_q, best_d;
  logic [15:0] y_k;
  logic [4:0] pc;
  logic stim_on;
  assign y_k = k_q == 2'd0 ? y0 : k_q == 2'd1 ? y1 : k_q == 2'd2 ? y2 : y3;
  mul4_popcount16 u_pc (.v_i(~(y_k ^ EXP_VEC[k_q])), .cnt_o(pc));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      sel_q      <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      sel_q      <= sel_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    sel_d      = sel_q;
    acc_d      = acc_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = mul4_eval_pkg::SETTLE;
        cnt_d      = '0;
        sel_d      = '0;
        acc_d      = '0;
        best_d     = '0;
        best_idx_d = '0;
      end
      mul4_eval_pkg::SETTLE: begin
        cnt_d   = cnt_q == CNT_W'(SETTLE - 1) ? '0 : cnt_q + 1'b1;
        k_d     = '0;
        state_d = cnt_q == CNT_W'(SETTLE - 1) ? SCORE : state_q;
      end
      SCORE: begin
        acc_d   = acc_q + SCORE_W'(pc);
        k_d     = k_q + 2'd1;
        state_d = k_q == 2'd3 ? UPDATE : state_q;
      end
      UPDATE: begin
        // Strict compare: ties keep the earlier (lower-index) winner
        if (sel_q == '0 || acc_q > best_q) begin
          best_d     = acc_q;
          best_idx_d = sel_q;
        end
        if (sel_q == IDX_W'(NUM_CAND - 1)) state_d = DONE;
        else begin
          sel_d   = sel_q + 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = mul4_eval_pkg::SETTLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign stim_on     = state_q == mul4_eval_pkg::SETTLE || state_q == SCORE || state_q == UPDATE;
  assign busy        = stim_on;
  assign done        = state_q == DONE;
  assign score_valid = state_q == UPDATE;
  assign score_idx   = score_valid ? sel_q : '0;
  assign score_out   = score_valid ? acc_q : '0;
  assign cand_sel    = sel_q;
  assign best_idx    = best_idx_q;
  assign best_score  = best_q;
  assign a1          = stim_on ? A1_VEC : '0;
  assign a0          = stim_on ? A0_VEC : '0;
  assign b1          = stim_on ? B1_VEC : '0;
  assign b0          = stim_on ? B0_VEC : '0;
endmodule

// File: tb/tb_mul4_fitness_sched.sv
// tb_mul4_fitness_sched: drives candidate models into the scheduler and checks scores, winner and timing against a lane-level model.
module tb_mul4_fitness_sched;
  logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0, use3 = 1'b0;
  int nvec = 0, nerr = 0;
  int kind [4];
  logic [15:0] rp [4][4];
  int age3 = 0;
  logic busy_a, done_a, sv_a, busy_b, done_b, sv_b;
  logic [1:0] cs_a, si_a, bi_a, cs_b, si_b, bi_b;
  logic [6:0] so_a, bs_a, so_b, bs_b;
  logic [15:0] a1_a, a0_a, b1_a, b0_a, a1_b, a0_b, b1_b, b0_b;
  logic [15:0] ya [4];
  logic [15:0] yb [4];
  logic o_busy, o_done, o_sv;
  logic [1:0] o_si, o_bi;
  logic [6:0] o_so, o_bs;
  logic [63:0] o_stim;
  int sv_cyc[$], sv_idx[$], sv_sc[$];
  int done_cyc, done_cnt, best_i, best_s, ms [4], mbi, mbs;
  logic busy1, busy_at_done;
  logic [63:0] stim1;

  always #5 clk = ~clk;

  mul4_fitness_sched dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .cand_sel(cs_a),
    .a1(a1_a), .a0(a0_a), .b1(b1_a), .b0(b0_a), .y3(ya[3]), .y2(ya[2]), .y1(ya[1]), .y0(ya[0]),
    .score_valid(sv_a), .score_idx(si_a), .score_out(so_a), .best_idx(bi_a), .best_score(bs_a));

  mul4_fitness_sched #(.SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .cand_sel(cs_b),
    .a1(a1_b), .a0(a0_b), .b1(b1_b), .b0(b0_b), .y3(yb[3]), .y2(yb[2]), .y1(yb[1]), .y0(yb[0]),
    .score_valid(sv_b), .score_idx(si_b), .score_out(so_b), .best_idx(bi_b), .best_score(bs_b));

  assign o_busy = use3 ? busy_b : busy_a;
  assign o_done = use3 ? done_b : done_a;
  assign o_sv   = use3 ? sv_b : sv_a;
  assign o_si   = use3 ? si_b : si_a;
  assign o_so   = use3 ? so_b : so_a;
  assign o_bi   = use3 ? bi_b : bi_a;
  assign o_bs   = use3 ? bs_b : bs_a;
  assign o_stim = use3 ? {a1_b, a0_b, b1_b, b0_b} : {a1_a, a0_a, b1_a, b0_a};

  // Bit k of lane i is bit k of (i[3:2] * i[1:0])
  function automatic logic [15:0] ideal(input int k);
    logic [15:0] w;
    int p;
    for (int i = 0; i < 16; i++) begin
      p = (i >> 2) * (i & 3);
      w[i] = p[k];
    end
    return w;
  endfunction

  // Candidate kinds: 0 ideal, 1 all-zero, 2 all-one, 3 random pattern, 4 ideal only after two settled cycles
  function automatic logic [15:0] word(input int kd, input int c, input int k, input int age);
    case (kd)
      0: return ideal(k);
      1: return 16'h0000;
      2: return 16'hFFFF;
      3: return rp[c][k];
      default: return age < 2 ? ~ideal(k) : ideal(k);
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ya[k] = word(kind[cs_a], int'(cs_a), k, 99);
      yb[k] = word(kind[cs_b], int'(cs_b), k, age3);
    end
  end

  always @(posedge clk) age3 <= (!busy_b || sv_b) ? 0 : age3 + 1;

  task automatic model_tournament();
    logic [15:0] w, e;
    for (int c = 0; c < 4; c++) begin
      ms[c] = 0;
      for (int k = 0; k < 4; k++) begin
        w = word(kind[c], c, k, 99);
        e = ideal(k);
        for (int i = 0; i < 16; i++) ms[c] += (w[i] == e[i]) ? 1 : 0;
      end
    end
    mbi = 0;
    mbs = ms[0];
    for (int c = 1; c < 4; c++) if (ms[c] > mbs) begin mbi = c; mbs = ms[c]; end
  endtask

  task automatic run_tournament(input int extra, input bit pulse5);
    int cyc;
    sv_cyc.delete(); sv_idx.delete(); sv_sc.delete();
    done_cyc = -1; done_cnt = 0; busy1 = 1'b0; busy_at_done = 1'b1; stim1 = '0;
    @(posedge clk); #1;
    if (use3) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      if (cyc == 1) begin busy1 = o_busy; stim1 = o_stim; end
      if (o_sv) begin sv_cyc.push_back(cyc); sv_idx.push_back(int'(o_si)); sv_sc.push_back(int'(o_so)); end
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = o_busy; best_i = int'(o_bi); best_s = int'(o_bs); end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + extra) break;
      if (pulse5 && cyc == 5) begin if (use3) start_b = 1'b1; else start_a = 1'b1; end
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      cyc++;
    end
    if (done_cyc < 0) begin
      nvec++; nerr++;
      $display("FAIL timeout: no done within %0d cycles (required one)", cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({busy_a, done_a, sv_a, cs_a, si_a, so_a, bi_a, bs_a, a1_a, a0_a, b1_a, b0_a} !== '0) begin
      nerr++;
      $display("FAIL reset_a: busy=%b done=%b sv=%b sel=%0d sidx=%0d sc=%0d bi=%0d bs=%0d a1=%h a0=%h b1=%h b0=%h, required all 0",
               busy_a, done_a, sv_a, cs_a, si_a, so_a, bi_a, bs_a, a1_a, a0_a, b1_a, b0_a);
    end
    nvec++;
    if ({busy_b, done_b, sv_b, cs_b, si_b, so_b, bi_b, bs_b, a1_b, a0_b, b1_b, b0_b} !== '0) begin
      nerr++;
      $display("FAIL reset_b: busy=%b done=%b sv=%b sel=%0d bi=%0d bs=%0d, required all 0", busy_b, done_b, sv_b, cs_b, bi_b, bs_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_scoring();
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: kind = '{0, 0, 0, 0};
        1: kind = '{1, 1, 0, 1};
        2: kind = '{2, 1, 2, 2};
        default: for (int c = 0; c < 4; c++) begin
          kind[c] = $urandom_range(0, 3);
          for (int k = 0; k < 4; k++) rp[c][k] = 16'($urandom);
        end
      endcase
      model_tournament();
      run_tournament(0, 1'b0);
      nvec++;
      if (busy1 !== 1'b1) begin nerr++; $display("FAIL busy_cycle1 s%0d: got %b required 1", s, busy1); end
      nvec++;
      if (stim1 !== 64'hFF00_F0F0_CCCC_AAAA) begin nerr++; $display("FAIL stimulus s%0d: got %h required ff00f0f0ccccaaaa", s, stim1); end
      nvec++;
      if (sv_cyc.size() != 4) begin nerr++; $display("FAIL score_count s%0d: got %0d required 4", s, sv_cyc.size()); end
      for (int n = 0; n < 4 && n < sv_cyc.size(); n++) begin
        nvec++;
        if (sv_cyc[n] != 1 + n * 6 + 5 || sv_idx[n] != n || sv_sc[n] != ms[n]) begin
          nerr++;
          $display("FAIL score s%0d cand%0d: cycle=%0d idx=%0d score=%0d required cycle=%0d idx=%0d score=%0d",
                   s, n, sv_cyc[n], sv_idx[n], sv_sc[n], 1 + n * 6 + 5, n, ms[n]);
        end
      end
      nvec++;
      if (done_cyc != 25 || done_cnt != 1 || busy_at_done !== 1'b0) begin
        nerr++;
        $display("FAIL done s%0d: cycle=%0d count=%0d busy=%b required cycle=25 count=1 busy=0", s, done_cyc, done_cnt, busy_at_done);
      end
      nvec++;
      if (best_i != mbi || best_s != mbs) begin
        nerr++;
        $display("FAIL best s%0d: idx=%0d score=%0d required idx=%0d score=%0d", s, best_i, best_s, mbi, mbs);
      end
    end
  endtask

  task automatic test_back_to_back();
    kind = '{1, 2, 1, 1};
    model_tournament();
    run_tournament(0, 1'b0);
    nvec++;
    if (best_i != mbi || best_s != mbs) begin nerr++; $display("FAIL b2b_first best: idx=%0d score=%0d required idx=%0d score=%0d", best_i, best_s, mbi, mbs); end
    kind = '{2, 2, 2, 0};
    model_tournament();
    run_tournament(0, 1'b0);
    nvec++;
    if (done_cyc != 25 || best_i != mbi || best_s != mbs) begin
      nerr++;
      $display("FAIL b2b_second: done=%0d idx=%0d score=%0d required done=25 idx=%0d score=%0d", done_cyc, best_i, best_s, mbi, mbs);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    kind = '{0, 0, 0, 0};
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nvec++;
    if ({busy_a, done_a, sv_a, cs_a, si_a, so_a, bi_a, bs_a, a1_a, a0_a, b1_a, b0_a} !== '0) begin
      nerr++;
      $display("FAIL reset_mid: busy=%b done=%b sv=%b sel=%0d bi=%0d bs=%0d a1=%h, required all 0", busy_a, done_a, sv_a, cs_a, bi_a, bs_a, a1_a);
    end
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (done_a || sv_a || busy_a) seen++; end
    nvec++;
    if (seen != 0) begin nerr++; $display("FAIL reset_mid_quiet: %0d active cycles after abort, required 0", seen); end
    model_tournament();
    run_tournament(0, 1'b0);
    nvec++;
    if (done_cyc != 25 || best_i != mbi || best_s != mbs) begin
      nerr++;
      $display("FAIL reset_mid_restart: done=%0d idx=%0d score=%0d required done=25 idx=%0d score=%0d", done_cyc, best_i, best_s, mbi, mbs);
    end
  endtask

  task automatic test_double_start();
    kind = '{2, 0, 1, 0};
    model_tournament();
    run_tournament(15, 1'b1);
    nvec++;
    if (done_cyc != 25 || done_cnt != 1 || sv_cyc.size() != 4) begin
      nerr++;
      $display("FAIL double_start: done=%0d dones=%0d scores=%0d required done=25 dones=1 scores=4", done_cyc, done_cnt, sv_cyc.size());
    end
  endtask

  task automatic test_settle3();
    use3 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      kind = r == 0 ? '{4, 4, 4, 4} : '{4, 1, 4, 2};
      model_tournament();
      run_tournament(0, 1'b0);
      nvec++;
      if (sv_cyc.size() != 4) begin nerr++; $display("FAIL settle3_count r%0d: got %0d required 4", r, sv_cyc.size()); end
      for (int n = 0; n < 4 && n < sv_cyc.size(); n++) begin
        nvec++;
        if (sv_cyc[n] != 1 + n * 8 + 7 || sv_idx[n] != n || sv_sc[n] != ms[n]) begin
          nerr++;
          $display("FAIL settle3_score r%0d cand%0d: cycle=%0d idx=%0d score=%0d required cycle=%0d idx=%0d score=%0d",
                   r, n, sv_cyc[n], sv_idx[n], sv_sc[n], 1 + n * 8 + 7, n, ms[n]);
        end
      end
      nvec++;
      if (done_cyc != 33 || best_i != mbi || best_s != mbs) begin
        nerr++;
        $display("FAIL settle3_done r%0d: done=%0d idx=%0d score=%0d required done=33 idx=%0d score=%0d", r, done_cyc, best_i, best_s, mbi, mbs);
      end
    end
    use3 = 1'b0;
  endtask

  initial begin
    kind = '{0, 0, 0, 0};
    for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) rp[c][k] = '0;
    test_reset();
    test_scoring();
    test_back_to_back();
    test_reset_mid();
    test_double_start();
    test_settle3();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
